// File: rtl/pad_trim_seq_pkg.sv
// Shared types and constants for the pad trim power-up sequencer.
// Included by pad_trim_seq and pad_trim_ocv_mon.
package pad_trim_seq_pkg;

  localparam int MAX_DRV_FINGERS = 5;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    LOAD,
    RAMP,
    OCV,
    DONE
  } state_e;

  typedef struct packed {
    logic pu;
    logic weakpu;
    logic weakpd;
  } pad_trim_t;

  function automatic logic [2:0] clamp_lvl(input logic [2:0] lvl);
    return (lvl > 3'(MAX_DRV_FINGERS)) ? 3'(MAX_DRV_FINGERS) : lvl;
  endfunction

  // Weak pull-up and pull-down must never fight; pull-up wins.
  function automatic pad_trim_t resolve_trim(input pad_trim_t p);
    pad_trim_t r;
    r = p;
    if (p.weakpu && p.weakpd) r.weakpd = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/pad_trim_seq_ocv_mon.sv
// Clock-out monitor: 2-flop synchronizer plus saturating rising-edge counter.
// pass_o reflects the count including an edge seen on the current cycle.
module pad_trim_ocv_mon
  import pad_trim_seq_pkg::*;
#(
  parameter int OCV_MIN_EDGES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic mon_i,
  input  logic clr_i,
  input  logic en_i,
  output logic pass_o
);

  localparam int CNT_W = $clog2(OCV_MIN_EDGES + 2);

  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  always_comb begin
    sync_d = {sync_q[0], mon_i};
    prev_d = sync_q[1];
    rise   = sync_q[1] & ~prev_q;
    cnt_d  = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (en_i && rise && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    pass_o = (cnt_d >= CNT_W'(OCV_MIN_EDGES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/pad_trim_seq.sv
// Pad trim power-up sequencer: bias settle, per-pad trim load, drive-finger ramp,
// optional clock-out check (enabled by macro PAD_TRIM_SEQ_OCV_CHECK_EN).
module pad_trim_seq
  import pad_trim_seq_pkg::*;
#(
  parameter int SETTLE_CYC    = 16,
  parameter int STEP_CYC      = 4,
  parameter int OCV_WIN       = 32,
  parameter int OCV_MIN_EDGES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [8:0] trim_cfg,
  input  logic [2:0] drv_level,
  input  logic       ckout_ocv_monitor,
  output logic       ana_en,
  output logic       pu_trim_0,
  output logic       pu_trim_1,
  output logic       pu_trim_2,
  output logic       weakpu_trim_0,
  output logic       weakpu_trim_1,
  output logic       weakpu_trim_2,
  output logic       weakpd_trim_0,
  output logic       weakpd_trim_1,
  output logic       weakpd_trim_2,
  output logic [4:0] ckouta_dr_en,
  output logic       busy,
  output logic       done,
  output logic       ocv_fail
);

  localparam int CNT_W = 16;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pad_trim_t [2:0]  cfg_q, cfg_d, pad_q, pad_d;
  logic [2:0]       lvl_q, lvl_d, nfing_q, nfing_d;
  logic [4:0]       dr_q, dr_d;
  logic             ana_q, ana_d, done_q, done_d, fail_q, fail_d;

`ifdef PAD_TRIM_SEQ_OCV_CHECK_EN
  logic mon_pass;

  pad_trim_ocv_mon #(.OCV_MIN_EDGES(OCV_MIN_EDGES)) u_ocv_mon (
    .clk    (clk),
    .rst    (rst),
    .mon_i  (ckout_ocv_monitor),
    .clr_i  (state_q != OCV),
    .en_i   (state_q == OCV),
    .pass_o (mon_pass)
  );
`else
  logic unused_ocv;
  assign unused_ocv = ckout_ocv_monitor ^ (OCV_WIN != 0) ^ (OCV_MIN_EDGES != 0);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    pad_d   = pad_q;
    lvl_d   = lvl_q;
    nfing_d = nfing_q;
    dr_d    = dr_q;
    ana_d   = ana_q;
    fail_d  = fail_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        cfg_d   = trim_cfg;
        lvl_d   = clamp_lvl(drv_level);
        pad_d   = '0;
        dr_d    = '0;
        nfing_d = '0;
        fail_d  = 1'b0;
        ana_d   = 1'b1;
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        for (int k = 0; k < 3; k++)
          if (cnt_q == CNT_W'(k)) pad_d[k] = resolve_trim(cfg_q[k]);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(2)) begin
          cnt_d   = '0;
          state_d = RAMP;
        end
      end
      RAMP: begin
        // Target reached (or level 0): leave without waiting another step.
        if (nfing_q == lvl_q) begin
          cnt_d = '0;
`ifdef PAD_TRIM_SEQ_OCV_CHECK_EN
          state_d = OCV;
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end else if (cnt_q == CNT_W'(STEP_CYC - 1)) begin
          cnt_d   = '0;
          dr_d    = {dr_q[3:0], 1'b1};
          nfing_d = nfing_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef PAD_TRIM_SEQ_OCV_CHECK_EN
      OCV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(OCV_WIN - 1)) begin
          cnt_d   = '0;
          fail_d  = ~mon_pass;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      cfg_d   = '0;
      pad_d   = '0;
      lvl_d   = '0;
      nfing_d = '0;
      dr_d    = '0;
      ana_d   = 1'b0;
      fail_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cfg_q   <= '0;
      pad_q   <= '0;
      lvl_q   <= '0;
      nfing_q <= '0;
      dr_q    <= '0;
      ana_q   <= 1'b0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      pad_q   <= pad_d;
      lvl_q   <= lvl_d;
      nfing_q <= nfing_d;
      dr_q    <= dr_d;
      ana_q   <= ana_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
    end
  end

  assign ana_en        = ana_q;
  assign pu_trim_0     = pad_q[0].pu;
  assign pu_trim_1     = pad_q[1].pu;
  assign pu_trim_2     = pad_q[2].pu;
  assign weakpu_trim_0 = pad_q[0].weakpu;
  assign weakpu_trim_1 = pad_q[1].weakpu;
  assign weakpu_trim_2 = pad_q[2].weakpu;
  assign weakpd_trim_0 = pad_q[0].weakpd;
  assign weakpd_trim_1 = pad_q[1].weakpd;
  assign weakpd_trim_2 = pad_q[2].weakpd;
  assign ckouta_dr_en  = dr_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign ocv_fail      = fail_q;

endmodule

// File: tb/tb_pad_trim_seq.sv
// Bench for pad_trim_seq: timeline reference model plus directed and random sequences.
// Honours PAD_TRIM_SEQ_OCV_CHECK_EN for the expected OCV window and result.
module tb_pad_trim_seq;

  localparam int SETTLE = 16;
  localparam int STEP   = 4;
  localparam int WIN    = 32;
  localparam int MINE   = 8;
`ifdef PAD_TRIM_SEQ_OCV_CHECK_EN
  localparam int OCV_EXTRA = WIN;
`else
  localparam int OCV_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, mon = 1'b0;
  logic [8:0] trim_cfg = '0;
  logic [2:0] drv_level = '0;
  logic       ana_en, busy, done, ocv_fail;
  logic       pu0, pu1, pu2, wu0, wu1, wu2, wd0, wd1, wd2;
  logic [4:0] dr_en;
  logic [8:0] pads;

  int n_cmp = 0, n_fail = 0, n_done = 0, done_cyc = 0;
  int cyc = 0, mon_half = 0;
  logic chk_on = 1'b0;

  // Reference model: latched request and the edge index at which it was accepted.
  logic       m_act = 1'b0;
  int         m_t0 = 0, m_td = 0;
  logic [8:0] m_cfg = '0;
  int         m_lvl = 0;
  logic       m_fail = 1'b0;

  pad_trim_seq #(.SETTLE_CYC(SETTLE), .STEP_CYC(STEP), .OCV_WIN(WIN), .OCV_MIN_EDGES(MINE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .trim_cfg(trim_cfg),
    .drv_level(drv_level), .ckout_ocv_monitor(mon), .ana_en(ana_en),
    .pu_trim_0(pu0), .pu_trim_1(pu1), .pu_trim_2(pu2),
    .weakpu_trim_0(wu0), .weakpu_trim_1(wu1), .weakpu_trim_2(wu2),
    .weakpd_trim_0(wd0), .weakpd_trim_1(wd1), .weakpd_trim_2(wd2),
    .ckouta_dr_en(dr_en), .busy(busy), .done(done), .ocv_fail(ocv_fail)
  );

  assign pads = {pu2, wu2, wd2, pu1, wu1, wd1, pu0, wu0, wd0};

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic int td_of(input int lvl);
    return SETTLE + 4 + lvl * STEP + 1 + OCV_EXTRA;
  endfunction

  function automatic logic fail_of(input int half);
    if (OCV_EXTRA == 0) return 1'b0;
    if (half == 0) return 1'b1;
    return (WIN / (2 * half)) < MINE;
  endfunction

  function automatic logic [8:0] exp_pads(input int t);
    logic [8:0] r;
    logic [8:0] c;
    logic [2:0] p;
    r = '0;
    c = m_cfg;
    for (int k = 0; k < 3; k++) begin
      p = c[3*k +: 3];
      if (p[1] && p[0]) p[0] = 1'b0;
      if (t >= SETTLE + 2 + k) r[3*k +: 3] = p;
    end
    return r;
  endfunction

  function automatic logic [4:0] exp_dr(input int t);
    int n;
    n = (t < SETTLE + 4) ? 0 : (t - SETTLE - 4) / STEP;
    if (n > m_lvl) n = m_lvl;
    return 5'((1 << n) - 1);
  endfunction

  function automatic logic m_busy();
    return m_act && (cyc - m_t0 >= 1) && (cyc - m_t0 <= m_td);
  endfunction

  always @(posedge clk) begin
    if (rst || abort) m_act <= 1'b0;
    else if (start && !m_busy()) begin
      m_act  <= 1'b1;
      m_t0   <= cyc;
      m_cfg  <= trim_cfg;
      m_lvl  <= (drv_level > 3'd5) ? 5 : int'(drv_level);
      m_td   <= td_of((drv_level > 3'd5) ? 5 : int'(drv_level));
      m_fail <= fail_of(mon_half);
    end
    cyc <= cyc + 1;
  end

  // Monitor stimulus: toggles every mon_half cycles, or stuck low when 0.
  always @(posedge clk) begin
    #3;
    if (mon_half == 0) mon = 1'b0;
    else if (cyc % mon_half == 0) mon = ~mon;
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (chk_on) begin
      if (rst || !m_act) begin
        check("idle_trims", pads, 9'h0);
        check("idle_dr", dr_en, 5'h0);
        check("idle_status", {ana_en, busy, done, ocv_fail}, 4'b0000);
      end else begin
        int t, tc;
        t  = cyc - m_t0;
        tc = (t > m_td) ? m_td : t;
        check("trims", pads, exp_pads(tc));
        check("dr_en", dr_en, exp_dr(tc));
        check("status", {ana_en, busy, done, ocv_fail},
              {1'b1, t <= m_td, t == m_td, (t >= m_td) ? m_fail : 1'b0});
      end
    end
  end

  task automatic run_seq(input logic [8:0] cfg, input logic [2:0] lvl, input int half, input int mode);
    int td, at;
    mon_half = half;
    trim_cfg = cfg;
    drv_level = lvl;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    td = td_of((lvl > 3'd5) ? 5 : int'(lvl));
    at = int'($urandom_range(td, 1));
    if (mode == 1) begin
      if (at > 1) tick(at - 1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      tick(3);
    end else if (mode == 2) begin
      if (at > 1) tick(at - 1);
      start = 1'b1;
      trim_cfg = 9'($urandom);
      drv_level = 3'($urandom);
      tick(1);
      start = 1'b0;
      tick(td - at + 3);
    end else begin
      tick(td + 2);
    end
    trim_cfg = 9'($urandom);
    tick(2);
  endtask

  initial begin
    int d0, s_cyc;
    tick(3);
    check("reset_outputs", {pads, dr_en, ana_en, busy, done, ocv_fail}, 18'h0);
    rst = 1'b0;
    tick(2);
    chk_on = 1'b1;

    // Nominal sequence with literal timing points.
    d0 = n_done;
    trim_cfg = 9'b101_010_100;
    drv_level = 3'd3;
    mon_half = 2;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("ana_en_t1", {ana_en, busy}, 2'b11);
    tick(16);
    check("pads_t17", pads, 9'h0);
    tick(1);
    check("pad0_t18", {pu0, wu0, wd0}, 3'b100);
    tick(1);
    check("pad1_t19", {pu1, wu1, wd1}, 3'b010);
    tick(1);
    check("pad2_t20", {pu2, wu2, wd2}, 3'b101);
    tick(3);
    check("dr_t23", dr_en, 5'b00000);
    tick(1);
    check("dr_t24", dr_en, 5'b00001);
    tick(4);
    check("dr_t28", dr_en, 5'b00011);
    tick(4);
    check("dr_t32", dr_en, 5'b00111);
    tick(4 + OCV_EXTRA);
    check("nominal_done_count", n_done - d0, 1);
    check("nominal_ocv_fail", ocv_fail, 1'b0);

    // Level clamp and weak pull conflict, monitor stuck low.
    trim_cfg = 9'b000_000_011;
    drv_level = 3'd7;
    mon_half = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(41 + OCV_EXTRA);
    check("clamp_dr", dr_en, 5'b11111);
    check("conflict_pad0", {pu0, wu0, wd0}, 3'b010);
`ifdef PAD_TRIM_SEQ_OCV_CHECK_EN
    check("stuck_ocv_fail", ocv_fail, 1'b1);
`else
    check("no_ocv_fail", ocv_fail, 1'b0);
`endif

    // Abort in RAMP after two fingers.
    d0 = n_done;
    trim_cfg = 9'b111_111_111;
    drv_level = 3'd3;
    mon_half = 2;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(28);
    check("abort_pre_dr", dr_en, 5'b00011);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_outputs", {pads, dr_en, ana_en, busy, done, ocv_fail}, 18'h0);
    tick(40 + OCV_EXTRA);
    check("abort_no_done", n_done - d0, 0);

    // Asynchronous reset during SETTLE, then a full sequence.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    rst = 1'b1;
    #1;
    check("rst_async_ana", {ana_en, busy, dr_en}, 7'h0);
    tick(1);
    rst = 1'b0;
    tick(1);
    run_seq(9'b001_100_110, 3'd2, 1, 0);

    // Start while busy is ignored; single done at the nominal latency.
    d0 = n_done;
    trim_cfg = 9'b010_001_100;
    drv_level = 3'd3;
    mon_half = 1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    s_cyc = cyc;
    tick(5);
    start = 1'b1;
    drv_level = 3'd1;
    trim_cfg = 9'h1ff;
    tick(1);
    start = 1'b0;
    tick(30 + OCV_EXTRA);
    check("busy_start_done_count", n_done - d0, 1);
    check("busy_start_latency", done_cyc - s_cyc + 1, 33 + OCV_EXTRA);
    check("busy_start_ocv_fail", ocv_fail, 1'b0);

    for (int i = 0; i < 12; i++) begin
      int half;
      case ($urandom_range(3, 0))
        0: half = 0;
        1: half = 1;
        2: half = 2;
        default: half = 4;
      endcase
      run_seq(9'($urandom), 3'($urandom), half, int'($urandom_range(2, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
